fp_div_seq: RTL and testbench

//   Iterative, parametrised IEEE-754 floating-point divider: result = operand_a / operand_b.

---
 rtl/fp_div_seq.sv | 199 +++++++++++++++++++
 tb/tb_fp_div_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 divider (result = operand_a / operand_b).
// One restoring quotient bit per cycle, round-to-nearest-even, flush-to-zero
// subnormals, valid/ready handshake on both sides.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] operand_a,
  input  logic [W-1:0] operand_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags
);

  localparam int EW2   = EXP_W + 2;
  localparam int SW    = MAN_W + 1;
  localparam int RW    = MAN_W + 2;
  localparam int QW    = MAN_W + 3;
  localparam int CNT_W = $clog2(QW);

  localparam logic [EW2-1:0]   BIAS      = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW2-1:0]   EXP_MAX   = EW2'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QW - 1);
  localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     a_q, b_q;
  logic             sign_q;
  logic [EW2-1:0]   exp_q;
  logic [SW-1:0]    div_q;
  logic [RW-1:0]    rem_q;
  logic [QW-1:0]    quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     result_q;
  logic [4:0]       flags_q;
  logic             out_valid_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sign_d;
  logic [EW2-1:0]   exp_d;
  logic             spec_hit;
  logic [W-1:0]     spec_res;
  logic [4:0]       spec_flags;

  logic             rem_ge;
  logic [RW-1:0]    rem_sub, rem_d;
  logic [QW-1:0]    quo_d;

  logic [QW-1:0]    quo_norm;
  logic [EW2-1:0]   exp_norm, exp_rnd;
  logic [SW-1:0]    mant;
  logic             guard_bit, sticky_bit, round_up, inexact;
  logic [SW:0]      mant_rnd;
  logic [MAN_W-1:0] frac_rnd;
  logic [W-1:0]     round_res;
  logic [4:0]       round_flags;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Split captured operands, classify them and resolve the special-case result.
  always_comb begin
    ea     = a_q[W-2 -: EXP_W];
    eb     = b_q[W-2 -: EXP_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    sign_d = a_q[W-1] ^ b_q[W-1];
    exp_d  = {2'b00, ea} - {2'b00, eb} + BIAS;
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = QNAN;
      spec_flags = 5'b10000;
    end else if (a_inf) begin
      spec_res = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_res   = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags = 5'b01000;
    end else if (b_inf || a_zero) begin
      spec_res = {sign_d, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring-division step: subtract when possible, shift the partial remainder.
  always_comb begin
    rem_ge  = (rem_q >= RW'(div_q));
    rem_sub = rem_ge ? (rem_q - RW'(div_q)) : rem_q;
    rem_d   = {rem_sub[RW-2:0], 1'b0};
    quo_d   = {quo_q[QW-2:0], rem_ge};
  end

  // Normalise the quotient, round to nearest even and detect range overflow/underflow.
  always_comb begin
    quo_norm   = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
    exp_norm   = quo_q[QW-1] ? exp_q : (exp_q - EW2'(1));
    mant       = quo_norm[QW-1:2];
    guard_bit  = quo_norm[1];
    sticky_bit = quo_norm[0] | (|rem_q);
    round_up   = guard_bit & (sticky_bit | mant[0]);
    inexact    = guard_bit | sticky_bit;
    mant_rnd   = {1'b0, mant} + (SW+1)'(round_up);
    if (mant_rnd[SW]) begin
      exp_rnd  = exp_norm + EW2'(1);
      frac_rnd = mant_rnd[MAN_W:1];
    end else begin
      exp_rnd  = exp_norm;
      frac_rnd = mant_rnd[MAN_W-1:0];
    end
    if (!exp_rnd[EW2-1] && (exp_rnd >= EXP_MAX)) begin
      round_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags = 5'b00101;
    end else if (exp_rnd[EW2-1] || (exp_rnd == '0)) begin
      round_res   = {sign_q, {(W-1){1'b0}}};
      round_flags = 5'b00011;
    end else begin
      round_res   = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
      round_flags = {4'b0000, inexact};
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= operand_a;
            b_q     <= operand_b;
            flags_q <= '0;
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= sign_d;
          exp_q  <= exp_d;
          div_q  <= {1'b1, fb};
          rem_q  <= {1'b0, 1'b1, fa};
          quo_q  <= '0;
          cnt_q  <= '0;
          if (spec_hit) begin
            result_q <= spec_res;
            flags_q  <= spec_flags;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_q <= S_ROUND;
        end
        S_ROUND: begin
          result_q <= round_res;
          flags_q  <= round_flags;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed scoreboard bench for the iterative FP divider.
module tb_fp_div_seq;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [7:0]  lat;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA, opB;
  logic        outValid;
  logic        outReady;
  logic [31:0] resultOut;
  logic [4:0]  flagsOut;

  expect_t expQ[$];
  int      assertCount = 0;
  int      failCount = 0;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .operand_a (opA),
    .operand_b (opB),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (resultOut),
    .flags     (flagsOut)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the design never answers.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=hang expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one operand pair, wait for acceptance and record the expected outcome.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expRes,
                               input logic [4:0] expFlags, input int expLat, input string tag);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (inReady !== 1'b1 && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    checkEq({tag, "_acceptReady"}, 32'(inReady), 32'd1);
    opA = a;
    opB = b;
    inValid = 1'b1;
    @(posedge clk);
    expQ.push_back(expect_t'{res: expRes, flg: expFlags, lat: 8'(expLat)});
    #1;
    inValid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally hold backpressure, then handshake.
  task automatic checkOutput(input string tag, input int holdCycles);
    expect_t e;
    int cycles;
    cycles = 0;
    while (outValid !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkEq({tag, "_outValid"}, 32'(outValid), 32'd1);
    checkEq({tag, "_queueDepth"}, 32'(expQ.size()), 32'd1);
    if (expQ.size() > 0) e = expQ.pop_front();
    else e = '0;
    checkEq({tag, "_result"}, resultOut, e.res);
    checkEq({tag, "_flags"}, 32'(flagsOut), 32'(e.flg));
    checkEq({tag, "_latency"}, 32'(cycles), 32'(e.lat));
    for (int i = 0; i < holdCycles; i++) begin
      inValid = 1'b1;
      opA = $urandom;
      opB = $urandom;
      @(posedge clk);
      #1;
      checkEq({tag, "_holdResult"}, resultOut, e.res);
      checkEq({tag, "_holdFlags"}, 32'(flagsOut), 32'(e.flg));
      checkEq({tag, "_holdValid"}, 32'(outValid), 32'd1);
      checkEq({tag, "_holdInReady"}, 32'(inReady), 32'd0);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkEq({tag, "_postValid"}, 32'(outValid), 32'd0);
    checkEq({tag, "_postReady"}, 32'(inReady), 32'd1);
  endtask

  // Directed sequence: reset, arithmetic and special cases, backpressure, mid-divide reset.
  initial begin
    int sawValid;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    opA = '0;
    opB = '0;
    repeat (3) @(posedge clk);
    #1;
    checkEq("reset_inReady", 32'(inReady), 32'd1);
    checkEq("reset_outValid", 32'(outValid), 32'd0);
    checkEq("reset_result", resultOut, 32'h0);
    checkEq("reset_flags", 32'(flagsOut), 32'd0);
    rst = 1'b0;

    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, "div6by2");
    checkOutput("div6by2", 0);
    applyStimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29, "div1by3");
    checkOutput("div1by3", 0);
    applyStimulus(32'h41200000, 32'h40400000, 32'h40555555, 5'b00001, 29, "div10by3");
    checkOutput("div10by3", 0);
    applyStimulus(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 29, "div2by3");
    checkOutput("div2by3", 0);
    applyStimulus(32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000, 29, "minNormBy1");
    checkOutput("minNormBy1", 0);
    applyStimulus(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 29, "overflow");
    checkOutput("overflow", 0);
    applyStimulus(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29, "underflow");
    checkOutput("underflow", 0);
    applyStimulus(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, "div1by0");
    checkOutput("div1by0", 0);
    applyStimulus(32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 2, "divNeg1by0");
    checkOutput("divNeg1by0", 0);
    applyStimulus(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, "div0by0");
    checkOutput("div0by0", 0);
    applyStimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2, "nanOperand");
    checkOutput("nanOperand", 0);
    applyStimulus(32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2, "infByInf");
    checkOutput("infByInf", 0);
    applyStimulus(32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 2, "infBy2");
    checkOutput("infBy2", 0);
    applyStimulus(32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 2, "neg2ByInf");
    checkOutput("neg2ByInf", 0);
    applyStimulus(32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2, "negZeroBy2");
    checkOutput("negZeroBy2", 0);
    applyStimulus(32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2, "subnormBy1");
    checkOutput("subnormBy1", 0);

    applyStimulus(32'hBF800000, 32'h40800000, 32'hBE800000, 5'b00000, 29, "backpressure");
    checkOutput("backpressure", 10);
    sawValid = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (outValid !== 1'b0) sawValid = 1;
    end
    checkEq("backpressure_noExtraResult", 32'(sawValid), 32'd0);

    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, "abortedOp");
    repeat (11) @(posedge clk);
    #1;
    checkEq("midDivide_busy", 32'(inReady), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkEq("midReset_inReady", 32'(inReady), 32'd1);
    checkEq("midReset_outValid", 32'(outValid), 32'd0);
    expQ.delete();
    sawValid = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (outValid !== 1'b0) sawValid = 1;
    end
    checkEq("midReset_noResult", 32'(sawValid), 32'd0);
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, "afterReset6by2");
    checkOutput("afterReset6by2", 0);

    checkEq("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
